// File: rtl/mont_precompute_pkg.sv
// Shared encodings, widths and milestones for the Montgomery constant precompute block.
package mont_precompute_pkg;

  localparam int NBITS   = 1024;
  localparam int ITER_R  = 1024;
  localparam int ITER_R2 = 2048;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DOUBLE = 3'd2,
    SUB    = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Keep 2x - m when it did not borrow, otherwise keep 2x.
  function automatic logic [NBITS:0] reduce_step(input logic [NBITS+1:0] diff,
                                                 input logic [NBITS:0]   x);
    return diff[NBITS+1] ? x : diff[NBITS:0];
  endfunction

endpackage

// File: rtl/mont_precompute_adder.sv
// Two-stage 1025-bit add/subtract: low half on start, high half on shift; done pulses 2 cycles after start.
// No backpressure: result and done are a single-cycle report, the caller must be listening.
module adder
  import mont_precompute_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             shift,
  input  logic             subtract,
  input  logic [NBITS:0]   in_a,
  input  logic [NBITS:0]   in_b,
  output logic [NBITS+1:0] result,
  output logic             done
);

  localparam int WIDTH = NBITS + 2;
  localparam int LO    = WIDTH / 2;
  localparam int HI    = WIDTH - LO;

  logic [WIDTH-1:0] a_ext;
  logic [WIDTH-1:0] b_ext;
  logic [LO:0]      lo_sum;
  logic [HI-1:0]    hi_sum;
  logic [HI-1:0]    hi_a;
  logic [HI-1:0]    hi_b;
  logic [LO-1:0]    lo_r;
  logic             carry_r;
  logic             busy;

  // Subtraction is a + ~b + 1 over the sign-extended width; bit WIDTH-1 is the borrow.
  assign a_ext  = {1'b0, in_a};
  assign b_ext  = subtract ? ~{1'b0, in_b} : {1'b0, in_b};
  assign lo_sum = {1'b0, a_ext[LO-1:0]} + {1'b0, b_ext[LO-1:0]} + {{LO{1'b0}}, subtract};
  assign hi_sum = hi_a + hi_b + {{(HI-1){1'b0}}, carry_r};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_a    <= '0;
      hi_b    <= '0;
      lo_r    <= '0;
      carry_r <= 1'b0;
      busy    <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        hi_a    <= a_ext[WIDTH-1:LO];
        hi_b    <= b_ext[WIDTH-1:LO];
        lo_r    <= lo_sum[LO-1:0];
        carry_r <= lo_sum[LO];
        busy    <= 1'b1;
      end else if (busy && shift) begin
        result <= {hi_sum, lo_r};
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mont_precompute.sv
// Computes R mod m and R^2 mod m (R = 2^1024) by 2048 modular doublings; 2 + 2048*(2+L) cycles from start.
// No backpressure: start restarts at any time, done holds until the next start or reset.
module mont_precompute
  import mont_precompute_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [NBITS-1:0] in_m,
  output logic [NBITS-1:0] R_modm,
  output logic [NBITS-1:0] R2_modm,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [NBITS:0]   x;
  logic [11:0]      cnt;
  logic             issued;
  logic             add_start;
  logic             add_shift;
  logic             add_sub;
  logic             add_done;
  logic [NBITS+1:0] add_result;
  logic [NBITS:0]   x_red;
  logic             last_r;
  logic             last_r2;

  assign last_r  = (cnt == 12'(ITER_R - 1));
  assign last_r2 = (cnt == 12'(ITER_R2 - 1));
  assign x_red   = reduce_step(add_result, x);
  assign done    = (state == DONE);

  always_comb begin
    add_start = 1'b0;
    add_sub   = 1'b0;
    if (state == SUB) begin
      add_start = !issued;
      add_sub   = 1'b1;
    end
    add_shift = ~add_start;
  end

  adder u_adder (
    .clk      (clk),
    .resetn   (resetn),
    .start    (add_start),
    .shift    (add_shift),
    .subtract (add_sub),
    .in_a     (x),
    .in_b     ({1'b0, in_m}),
    .result   (add_result),
    .done     (add_done)
  );

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        LOAD:    state_nxt = DOUBLE;
        DOUBLE:  state_nxt = SUB;
        SUB:     if (add_done) state_nxt = last_r2 ? DONE : DOUBLE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A start in the same cycle as adder done discards that result.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      x       <= '0;
      cnt     <= '0;
      issued  <= 1'b0;
      R_modm  <= '0;
      R2_modm <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        cnt    <= '0;
        issued <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            x   <= {{NBITS{1'b0}}, 1'b1};
            cnt <= '0;
          end
          DOUBLE: begin
            x      <= x << 1;
            issued <= 1'b0;
          end
          SUB: begin
            issued <= 1'b1;
            if (add_done) begin
              x   <= x_red;
              cnt <= cnt + 12'd1;
              if (last_r)  R_modm  <= x_red[NBITS-1:0];
              if (last_r2) R2_modm <= x_red[NBITS-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mont_precompute.sv
// Scoreboarded bench for mont_precompute against a direct bignum modulo model.
module tb_mont_precompute;
  import mont_precompute_pkg::*;

  localparam int FULL_LAT = 8194;
  localparam int MAX_CYC  = 9000;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [NBITS-1:0] in_m = '0;
  logic [NBITS-1:0] R_modm;
  logic [NBITS-1:0] R2_modm;
  logic             done;

  typedef struct {
    logic [NBITS-1:0] r;
    logic [NBITS-1:0] r2;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  mont_precompute dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .in_m    (in_m),
    .R_modm  (R_modm),
    .R2_modm (R2_modm),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic logic [NBITS-1:0] pow2_mod(input logic [NBITS-1:0] m, input int k);
    logic [2048:0] p;
    logic [2048:0] mm;
    logic [2048:0] q;
    p = '0;
    p[k] = 1'b1;
    mm = {1025'd0, m};
    q = p % mm;
    return q[NBITS-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_start(input logic [NBITS-1:0] m);
    @(negedge clk);
    in_m  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic advance_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_done(output int lat);
    while (done !== 1'b1 && cyc < MAX_CYC) step();
    lat = (done === 1'b1) ? cyc : -1;
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (R_modm !== '0) begin n_bad++; $display("FAIL reset_r: got %h want 0", R_modm[63:0]); end
    n_cmp++; if (R2_modm !== '0) begin n_bad++; $display("FAIL reset_r2: got %h want 0", R2_modm[63:0]); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dut.state); end
    @(negedge clk);
    start  = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic test_m11();
    exp_t e;
    int   lat;
    int   held_bad;
    sb.push_back('{r: 1024'd5, r2: 1024'd3, lat: FULL_LAT});
    pulse_start(1024'd11);
    advance_to(4097);
    n_cmp++; if (R_modm !== '0) begin n_bad++; $display("FAIL m11_r_early: got %h want 0", R_modm[63:0]); end
    step();
    n_cmp++; if (R_modm !== 1024'd5) begin n_bad++; $display("FAIL m11_r_ontime: got %h want 5", R_modm[63:0]); end
    wait_done(lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL m11_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (R_modm !== e.r) begin n_bad++; $display("FAIL m11_r: got %h want %h", R_modm[63:0], e.r[63:0]); end
    n_cmp++; if (R2_modm !== e.r2) begin n_bad++; $display("FAIL m11_r2: got %h want %h", R2_modm[63:0], e.r2[63:0]); end
    held_bad = 0;
    repeat (100) begin
      step();
      if (done !== 1'b1 || R_modm !== e.r || R2_modm !== e.r2) held_bad++;
    end
    n_cmp++; if (held_bad !== 0) begin n_bad++; $display("FAIL m11_hold: %0d bad cycles want 0", held_bad); end
  endtask

  task automatic test_adder_collision();
    exp_t e;
    int   lat;
    pulse_start(1024'd7);
    advance_to(4097);
    n_cmp++; if (dut.u_adder.done !== 1'b1) begin n_bad++; $display("FAIL coll_adder_done: got %0b want 1", dut.u_adder.done); end
    start = 1'b1;
    sb.push_back('{r: 1024'd2, r2: 1024'd4, lat: FULL_LAT});
    step();
    start = 1'b0;
    cyc   = 1;
    n_cmp++; if (dut.state !== LOAD) begin n_bad++; $display("FAIL coll_state: got %0d want 1", dut.state); end
    n_cmp++; if (dut.cnt !== 12'd0) begin n_bad++; $display("FAIL coll_cnt: got %0d want 0", dut.cnt); end
    n_cmp++; if (R_modm !== 1024'd5) begin n_bad++; $display("FAIL coll_r_kept: got %h want 5", R_modm[63:0]); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL coll_done: got %0b want 0", done); end
    wait_done(lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL coll_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (R_modm !== e.r) begin n_bad++; $display("FAIL coll_r: got %h want %h", R_modm[63:0], e.r[63:0]); end
    n_cmp++; if (R2_modm !== e.r2) begin n_bad++; $display("FAIL coll_r2: got %h want %h", R2_modm[63:0], e.r2[63:0]); end
  endtask

  task automatic test_restart_midrun();
    exp_t e;
    int   lat;
    pulse_start(1024'd7);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst1_done_drop: got %0b want 0", done); end
    n_cmp++; if (R_modm !== 1024'd2) begin n_bad++; $display("FAIL rst1_r_kept: got %h want 2", R_modm[63:0]); end
    advance_to(2 + 4 * 1500);
    sb.push_back('{r: 1024'd5, r2: 1024'd3, lat: FULL_LAT});
    pulse_start(1024'd11);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst2_done: got %0b want 0", done); end
    n_cmp++; if (R_modm !== 1024'd2) begin n_bad++; $display("FAIL rst2_r_old: got %h want 2", R_modm[63:0]); end
    n_cmp++; if (R2_modm !== 1024'd4) begin n_bad++; $display("FAIL rst2_r2_old: got %h want 4", R2_modm[63:0]); end
    wait_done(lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL rst2_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (R_modm !== e.r) begin n_bad++; $display("FAIL rst2_r: got %h want %h", R_modm[63:0], e.r[63:0]); end
    n_cmp++; if (R2_modm !== e.r2) begin n_bad++; $display("FAIL rst2_r2: got %h want %h", R2_modm[63:0], e.r2[63:0]); end
  endtask

  task automatic test_all_ones();
    exp_t             e;
    int               lat;
    logic [NBITS-1:0] m;
    m = '1;
    sb.push_back('{r: 1024'd1, r2: 1024'd1, lat: FULL_LAT});
    pulse_start(m);
    wait_done(lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL ones_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (R_modm !== e.r) begin n_bad++; $display("FAIL ones_r: got %h want %h", R_modm[63:0], e.r[63:0]); end
    n_cmp++; if (R2_modm !== e.r2) begin n_bad++; $display("FAIL ones_r2: got %h want %h", R2_modm[63:0], e.r2[63:0]); end
  endtask

  task automatic test_random();
    exp_t             e;
    int               lat;
    logic [NBITS-1:0] m;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < NBITS / 32; w++) m[w*32 +: 32] = $urandom;
      m[NBITS-1] = 1'b1;
      m[0]       = 1'b1;
      sb.push_back('{r: pow2_mod(m, 1024), r2: pow2_mod(m, 2048), lat: FULL_LAT});
      pulse_start(m);
      wait_done(lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL rand%0d_lat: got %0d want %0d", s, lat, e.lat); end
      n_cmp++; if (R_modm !== e.r) begin n_bad++; $display("FAIL rand%0d_r: got %h want %h", s, R_modm[63:0], e.r[63:0]); end
      n_cmp++; if (R2_modm !== e.r2) begin n_bad++; $display("FAIL rand%0d_r2: got %h want %h", s, R2_modm[63:0], e.r2[63:0]); end
    end
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    int   lat;
    pulse_start(1024'd7);
    advance_to(2 + 4 * 500);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mrst_done: got %0b want 0", done); end
    n_cmp++; if (R_modm !== '0) begin n_bad++; $display("FAIL mrst_r: got %h want 0", R_modm[63:0]); end
    n_cmp++; if (R2_modm !== '0) begin n_bad++; $display("FAIL mrst_r2: got %h want 0", R2_modm[63:0]); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL mrst_state: got %0d want 0", dut.state); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL mrst_idle_hold: got %0d want 0", dut.state); end
    sb.push_back('{r: 1024'd5, r2: 1024'd3, lat: FULL_LAT});
    pulse_start(1024'd11);
    wait_done(lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL mrst_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (R_modm !== e.r) begin n_bad++; $display("FAIL mrst_r_final: got %h want %h", R_modm[63:0], e.r[63:0]); end
    n_cmp++; if (R2_modm !== e.r2) begin n_bad++; $display("FAIL mrst_r2_final: got %h want %h", R2_modm[63:0], e.r2[63:0]); end
  endtask

  initial begin
    test_reset();
    test_m11();
    test_adder_collision();
    test_restart_midrun();
    test_all_ones();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mont_precompute.md
# mont_precompute

Computes the two Montgomery constants R mod m and R² mod m (R = 2^1024) for a 1024-bit modulus by repeated modular doubling. It sits directly upstream of `montgomery_exp` and drives that block's `R_modm` and `R2_modm` inputs. The shared `adder` does the arithmetic, one conditional subtraction per doubling step.

## Interface
- `NBITS`, 1024: operand width; fixed by `adder` (1025-bit in, 1026-bit out). Not meant to be overridden.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a new computation, sampled in any state.
- `in_m`  in  1024  modulus m; must be held stable from `start` until `done`.
- `R_modm`  out  1024  2^1024 mod m; registered.
- `R2_modm`  out  1024  2^2048 mod m; registered.
- `done`  out  1  high while in DONE; stays high until the next `start` or reset.

## Operation
- Invariant: accumulator x (1025-bit) satisfies x < m after every reduction.
- Each iteration does two things:
  - x ← 2x.
  - If 2x − m ≥ 0, x ← 2x − m.
- One subtraction is sufficient because 2x < 2m.
- After 1024 iterations, x = R mod m. After 2048 iterations, x = R² mod m.
- States:
  - IDLE: reached on reset. Waits for `start`.
  - LOAD: x ← 1, iteration counter cnt (12-bit) ← 0. Always goes to DOUBLE.
  - DOUBLE: x ← x << 1. Goes to SUB.
  - SUB:
    - Adder inputs: in_a = x, in_b = {1'b0, in_m}, subtract = 1.
    - Adder start is pulsed in the first SUB cycle only. Adder shift = ~adder start.
    - Stays in SUB until adder `done`.
    - On `done`: if result[1025] == 0, x ← result[1024:0]; otherwise x is unchanged. cnt ← cnt+1.
    - On the `done` cycle with cnt == 1023: `R_modm` ← reduced x[1023:0]; go to DOUBLE.
    - On the `done` cycle with cnt == 2047: `R2_modm` ← reduced x[1023:0]; go to DONE.
    - Otherwise: go to DOUBLE.
  - DONE: `done` = 1. Holds both outputs.
- `start` while in any state other than IDLE goes to LOAD on the next edge and aborts the current run.
- `start` does not clear `R_modm` or `R2_modm`. The old values stay visible until they are overwritten; `done` drops immediately.
- Precondition: in_m odd and in_m > 1. For in_m ≤ 1 the outputs are unspecified, but the FSM must still reach DONE.

## Timing
- Reset (resetn = 0 at a rising edge):
  - state ← IDLE.
  - `done`, `R_modm`, `R2_modm`, x, cnt ← 0.
  - Adder start/subtract ← 0.
  - Reset has priority over `start`.
- Reset mid-run abandons the computation. No partial output is retained.
- Timeline for a `start` pulse at edge 0, with L = adder latency from start pulse to `done`:
  - LOAD at cycle 1; first DOUBLE at cycle 2.
  - Each iteration costs 2 + L cycles (DOUBLE 1, SUB issue 1, wait L−1, `done` cycle 1).
  - `R_modm` is valid from cycle 1 + 1024·(2+L) + 1.
  - `done` rises at cycle 2 + 2048·(2+L), together with valid `R2_modm`.
- No handshake to `montgomery_exp` beyond `done`. The integrator pulses `montgomery_exp.start` after `done` is seen.
- `start` and adder `done` in the same cycle: `start` wins and the adder result is discarded.

## Structure
- Shared package holds:
  - state encodings: IDLE = 0, LOAD = 1, DOUBLE = 2, SUB = 3, DONE = 4 (3-bit);
  - NBITS;
  - iteration milestones ITER_R = 1024 and ITER_R2 = 2048.
- One sub-module: the existing `adder`, instantiated once. All other logic stays inline (FSM, counter, accumulator, output registers).

## Test plan
- m = 11 → `R_modm` = 5, `R2_modm` = 3, `done` = 1 at cycle 2 + 2048·(2+L) and held for 100 cycles.
- m = 7 → `R_modm` = 2, `R2_modm` = 4. m = 2^1024 − 1 → both = 1.
- Random odd 1024-bit m (≥ 20 seeds, MSB set) → outputs match a bignum model. Feeding them into `montgomery_exp` with e = 65537 matches a modexp model.
- resetn low for 1 cycle at iteration 500 → all outputs 0 and IDLE next cycle. A new `start` with m = 11 → correct results.
- Second `start` at iteration 1500, with m changed from 7 to 11 → `done` drops next cycle; final outputs 5 / 3 with full latency measured from the second `start`.
- `start` on the same cycle as adder `done` → restart taken, cnt = 0 in LOAD, no output register written.
